frog_pos_ctrl: RTL and testbench

- Player position controller for the Frogger playfield, on both axes.
- Converts L/R/U/D button levels into single-step moves with edge detection and hold-to-repeat.
- Outputs a one-hot column pattern plus column and row indices to the display and collision logic.
- Returns the frog to its spawn cell on reset, win or lose. Sits between input synchronisers and the row renderer/collision checker.

---
 rtl/frog_pos_ctrl.sv | 150 +++++++++++++++
 tb/tb_frog_pos_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/frog_pos_ctrl.sv
// Frogger player position controller: turns L/R/U/D button levels into single-cell
// moves with per-axis press edge detection, hold-to-repeat and playfield edge clamping.
module frog_pos_ctrl #(
  parameter int COLS         = 16,
  parameter int ROWS         = 16,
  parameter int START_COL    = 8,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    L,
  input  logic                    R,
  input  logic                    U,
  input  logic                    D,
  input  logic                    enable,
  input  logic                    win_result,
  input  logic                    lose_result,
  output logic [COLS-1:0]         col_pattern,
  output logic [$clog2(COLS)-1:0] col_idx,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    moved,
  output logic                    at_goal
);

  localparam int COL_W     = $clog2(COLS);
  localparam int ROW_W     = $clog2(ROWS);
  localparam int MAX_RPT   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W     = $clog2(MAX_RPT + 1);

  localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD = CNT_W'(REPEAT_RATE - 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_SPAWN = COL_W'(START_COL);

  typedef enum logic [1:0] {S_LOCKED, S_IDLE, S_WAIT, S_REPEAT} axis_state_e;
  typedef enum logic [1:0] {D_NONE, D_POS, D_NEG} dir_e;

  // dir remembers the sign of the last issued move so a reversal can be spotted.
  typedef struct packed {
    axis_state_e      state;
    dir_e             dir;
    logic [CNT_W-1:0] cnt;
  } axis_t;

  typedef struct packed {
    axis_t st;
    dir_e  step;
  } axis_res_t;

  localparam axis_t AXIS_RESTART = '{state: S_LOCKED, dir: D_NONE, cnt: '0};

  function automatic axis_res_t axis_next(input axis_t cur, input dir_e req);
    axis_res_t res;
    res.st   = cur;
    res.step = D_NONE;
    unique case (cur.state)
      S_LOCKED: begin
        if (req == D_NONE) res.st.state = S_IDLE;
      end
      S_IDLE: begin
        if (req != D_NONE) begin
          res.step     = req;
          res.st.dir   = req;
          res.st.cnt   = DLY_LOAD;
          res.st.state = S_WAIT;
        end
      end
      S_WAIT, S_REPEAT: begin
        if (req == D_NONE) begin
          res.st.state = S_IDLE;
        end else if (req != cur.dir) begin
          res.step     = req;
          res.st.dir   = req;
          res.st.cnt   = DLY_LOAD;
          res.st.state = S_WAIT;
        end else if (cur.cnt == '0) begin
          res.step     = req;
          res.st.cnt   = RATE_LOAD;
          res.st.state = S_REPEAT;
        end else begin
          res.st.cnt   = cur.cnt - CNT_W'(1);
        end
      end
      default: res.st = AXIS_RESTART;
    endcase
    return res;
  endfunction

  axis_t            h_q, h_d, v_q, v_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             moved_q, moved_d;
  logic             at_goal_q, at_goal_d;

  dir_e      h_req, v_req;
  axis_res_t h_res, v_res;
  logic      restart;

  assign restart = reset | win_result | lose_result;
  assign h_req   = (L & ~R) ? D_POS : (R & ~L) ? D_NEG : D_NONE;
  assign v_req   = (U & ~D) ? D_POS : (D & ~U) ? D_NEG : D_NONE;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    h_res     = axis_next(h_q, h_req);
    v_res     = axis_next(v_q, v_req);
    h_d       = h_q;
    v_d       = v_q;
    col_d     = col_q;
    row_d     = row_q;
    moved_d   = 1'b0;

    if (restart) begin
      h_d   = AXIS_RESTART;
      v_d   = AXIS_RESTART;
      col_d = COL_SPAWN;
      row_d = '0;
    end else if (enable) begin
      h_d = h_res.st;
      v_d = v_res.st;
      // Steps past the playfield edge are dropped; the FSMs keep their timing.
      if (h_res.step == D_POS && col_q != COL_MAX) col_d = col_q + COL_W'(1);
      if (h_res.step == D_NEG && col_q != '0)      col_d = col_q - COL_W'(1);
      if (v_res.step == D_POS && row_q != ROW_MAX) row_d = row_q + ROW_W'(1);
      if (v_res.step == D_NEG && row_q != '0)      row_d = row_q - ROW_W'(1);
      moved_d = (col_d != col_q) || (row_d != row_q);
    end

    at_goal_d = (row_d == ROW_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    h_q       <= h_d;
    v_q       <= v_d;
    col_q     <= col_d;
    row_q     <= row_d;
    moved_q   <= moved_d;
    at_goal_q <= at_goal_d;
  end

  assign col_pattern = COLS'(1) << col_q;
  assign col_idx     = col_q;
  assign row_idx     = row_q;
  assign moved       = moved_q;
  assign at_goal     = at_goal_q;

endmodule

// File: tb/tb_frog_pos_ctrl.sv
// Directed bench for frog_pos_ctrl: a hold-time reference model pushes the expected
// post-edge outputs into a scoreboard queue; each cycle the DUT outputs are popped and compared.
module tb_frog_pos_ctrl;

  localparam int COLS = 16;
  localparam int ROWS = 10;
  localparam int START_COL = 8;
  localparam int RD = 8;
  localparam int RR = 4;
  localparam int VW = COLS + 4 + 4 + 2;

  logic clk = 1'b0;
  logic reset, L, R, U, D, enable, win_result, lose_result;
  logic [COLS-1:0] col_pattern;
  logic [3:0] col_idx;
  logic [3:0] row_idx;
  logic moved, at_goal;

  frog_pos_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .START_COL(START_COL),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .U(U), .D(D), .enable(enable),
    .win_result(win_result), .lose_result(lose_result),
    .col_pattern(col_pattern), .col_idx(col_idx), .row_idx(row_idx),
    .moved(moved), .at_goal(at_goal)
  );

  always #5 clk = ~clk;

  // Reference model: an axis is characterised by how long the same direction has been held.
  int m_col, m_row;
  bit m_locked[2];
  bit m_active[2];
  int m_t[2];
  int m_last[2];

  logic [VW-1:0] sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_cyc = 0;
  string phase = "reset";

  task automatic model_step();
    int dir[2];
    int step[2];
    int nc, nr;
    bit mv;
    logic [COLS-1:0] pat;
    dir[0] = (L && !R) ? 1 : (R && !L) ? -1 : 0;
    dir[1] = (U && !D) ? 1 : (D && !U) ? -1 : 0;
    mv = 1'b0;
    if (reset || win_result || lose_result) begin
      m_col = START_COL;
      m_row = 0;
      for (int a = 0; a < 2; a++) begin
        m_locked[a] = 1'b1;
        m_active[a] = 1'b0;
      end
    end else if (enable) begin
      for (int a = 0; a < 2; a++) begin
        step[a] = 0;
        if (m_locked[a]) begin
          if (dir[a] == 0) m_locked[a] = 1'b0;
        end else if (dir[a] == 0) begin
          m_active[a] = 1'b0;
        end else if (!m_active[a] || dir[a] != m_last[a]) begin
          m_active[a] = 1'b1;
          m_t[a] = 0;
          m_last[a] = dir[a];
          step[a] = dir[a];
        end else begin
          m_t[a]++;
          if (m_t[a] == RD || (m_t[a] > RD && (m_t[a] - RD) % RR == 0)) step[a] = dir[a];
        end
      end
      nc = m_col + step[0];
      nr = m_row + step[1];
      if (nc >= 0 && nc < COLS && nc != m_col) begin m_col = nc; mv = 1'b1; end
      if (nr >= 0 && nr < ROWS && nr != m_row) begin m_row = nr; mv = 1'b1; end
    end
    pat = '0;
    pat[m_col] = 1'b1;
    sb.push_back({pat, 4'(m_col), 4'(m_row), mv, (m_row == ROWS - 1)});
  endtask

  task automatic cyc(input int n);
    logic [VW-1:0] exp_v, obs_v;
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
      n_cyc++;
      exp_v = sb.pop_front();
      obs_v = {col_pattern, col_idx, row_idx, moved, at_goal};
      n_checks++;
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s cycle %0d: observed pat=%h col=%0d row=%0d moved=%b goal=%b, expected pat=%h col=%0d row=%0d moved=%b goal=%b",
               phase, n_cyc, obs_v[VW-1 -: COLS], obs_v[9:6], obs_v[5:2], obs_v[1], obs_v[0],
               exp_v[VW-1 -: COLS], exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic set_btn(input logic l, input logic r, input logic u, input logic d);
    L = l; R = r; U = u; D = d;
  endtask

  initial begin
    m_col = START_COL; m_row = 0;
    for (int a = 0; a < 2; a++) begin
      m_locked[a] = 1'b1; m_active[a] = 1'b0; m_t[a] = 0; m_last[a] = 0;
    end
    reset = 1'b1; enable = 1'b1; win_result = 1'b0; lose_result = 1'b0;
    set_btn(0, 0, 0, 0);
    #2;

    phase = "reset";        cyc(2);
    reset = 1'b0;
    phase = "idle";         cyc(5);

    phase = "l_pulse";      set_btn(1, 0, 0, 0); cyc(1);
    set_btn(0, 0, 0, 0);    cyc(2);
    phase = "l_hold";       set_btn(1, 0, 0, 0); cyc(20);
    phase = "l_release";    set_btn(0, 0, 0, 0); cyc(3);

    phase = "to_col14";     set_btn(1, 0, 0, 0); cyc(1);
    set_btn(0, 0, 0, 0);    cyc(1);
    phase = "clamp_left";   set_btn(1, 0, 0, 0); cyc(30);
    set_btn(0, 0, 0, 0);    cyc(1);
    phase = "clamp_right";  set_btn(0, 1, 0, 0); cyc(90);
    set_btn(0, 0, 0, 0);    cyc(1);

    phase = "l_and_r";      set_btn(1, 1, 0, 0); cyc(10);
    set_btn(0, 0, 0, 0);    cyc(1);
    phase = "u_hold";       set_btn(0, 0, 1, 0); cyc(12);
    phase = "u_and_d";      set_btn(0, 0, 1, 1); cyc(3);
    phase = "u_after_ud";   set_btn(0, 0, 1, 0); cyc(2);
    set_btn(0, 0, 0, 0);    cyc(1);

    phase = "lose_spawn";   lose_result = 1'b1; cyc(1);
    lose_result = 1'b0;     cyc(2);
    phase = "diagonal";     set_btn(1, 0, 1, 0); cyc(1);
    set_btn(0, 0, 0, 0);    cyc(2);

    phase = "win_spawn";    win_result = 1'b1; cyc(1);
    win_result = 1'b0;      cyc(2);
    phase = "u_to_goal";    set_btn(0, 0, 1, 0); cyc(45);
    phase = "win_u_held";   win_result = 1'b1; cyc(1);
    win_result = 1'b0;      cyc(15);
    phase = "u_repress";    set_btn(0, 0, 0, 0); cyc(2);
    set_btn(0, 0, 1, 0);    cyc(1);
    set_btn(0, 0, 0, 0);    cyc(2);

    phase = "r_wait_lose";  set_btn(0, 1, 0, 0); cyc(5);
    lose_result = 1'b1;     cyc(1);
    lose_result = 1'b0;     cyc(3);
    phase = "r_disabled";   enable = 1'b0; cyc(10);
    phase = "r_locked";     enable = 1'b1; cyc(5);
    phase = "r_fresh";      set_btn(0, 0, 0, 0); cyc(2);
    set_btn(0, 1, 0, 0);    cyc(1);
    set_btn(0, 0, 0, 0);    cyc(2);

    phase = "freeze_mid";   set_btn(1, 0, 0, 0); cyc(3);
    enable = 1'b0;          cyc(10);
    enable = 1'b1;          cyc(12);
    phase = "reset_disabled"; enable = 1'b0; reset = 1'b1; cyc(1);
    reset = 1'b0;           cyc(3);
    enable = 1'b1;          set_btn(0, 0, 0, 0); cyc(3);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
